// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Handshake note: the pipeline sees per-register Stall/Flush levels every
// cycle; a register advances when both are 0, holds on Stall, and loads a
// bubble on Flush. md_done and md_cancel are registered one-cycle pulses;
// every other output is combinational from state + inputs.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       exe_load,
  input  logic [4:0] exe_regdst,
  input  logic       exe_mul_start,
  input  logic       exe_div_start,
  input  logic       if_wait,
  input  logic       mem_wait,
  input  logic       exc_flush,
  output logic       PC_Stall,
  output logic       IF_ID_Stall,
  output logic       ID_EXE_Stall,
  output logic       EXE_MEM_Stall,
  output logic       MEM_WB_Stall,
  output logic       IF_ID_Flush,
  output logic       ID_EXE_Flush,
  output logic       EXE_MEM_Flush,
  output logic       MEM_WB_Flush,
  output logic       md_busy,
  output logic       md_done,
  output logic       md_cancel
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_pend;
  logic             r_md_done;
  logic             r_md_cancel;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_pend_nx;
  logic             w_done_nx;
  logic             w_cancel_nx;
  logic             w_flush_eff;
  logic             w_load_use;
  logic             w_start;
  logic [CNT_W-1:0] w_issue;
  logic [4:0]       w_stall;   // {PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB}
  logic [3:0]       w_flush;   // {IF_ID, ID_EXE, EXE_MEM, MEM_WB}
  logic             w_busy;

  assign w_flush_eff = (exc_flush | r_flush_pend) & ~mem_wait;
  assign w_start     = exe_mul_start | exe_div_start;
  assign w_issue     = exe_div_start ? DIV_LD : MUL_LD;
  assign w_load_use  = exe_load && (exe_regdst != 5'd0) &&
                       ((id_use_rs && (id_rs == exe_regdst)) ||
                        (id_use_rt && (id_rt == exe_regdst)));

  // State, counter and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_md_done    <= 1'b0;
      r_md_cancel  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_flush_pend <= w_pend_nx;
      r_md_done    <= w_done_nx;
      r_md_cancel  <= w_cancel_nx;
    end
  end

  // Next-state and stall/flush decode, highest-priority event first
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_pend_nx   = r_flush_pend;
    w_done_nx   = 1'b0;
    w_cancel_nx = 1'b0;
    w_stall     = 5'b00000;
    w_flush     = 4'b0000;
    w_busy      = (r_state == BUSY);

    if (w_flush_eff) begin
      // Exception wins: bubble everything, abort any MUL/DIV in flight
      w_flush     = 4'b1111;
      w_state_nx  = IDLE;
      w_cnt_nx    = '0;
      w_pend_nx   = 1'b0;
      w_cancel_nx = (r_state == BUSY);
      w_busy      = 1'b0;
    end else if (mem_wait) begin
      // Freeze the pipe; the MUL/DIV unit keeps counting but cannot finish
      w_stall = 5'b11111;
      if (exc_flush) w_pend_nx = 1'b1;
      if (r_cnt != '0) w_cnt_nx = r_cnt - CNT_ONE;
    end else begin
      // MUL/DIV sequencing runs regardless of front-end stalls
      if (r_state == BUSY) begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_done_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end else if (w_start && !if_wait) begin
        w_cnt_nx = w_issue;
        if (w_issue != '0) w_state_nx = BUSY;
        else               w_done_nx  = 1'b1;
      end

      if (if_wait) begin
        w_stall = 5'b11000;
        w_flush = 4'b0100;
      end else if ((r_state == BUSY) || w_start) begin
        // EXE occupied: hold front end, push bubbles into MEM
        w_stall = 5'b11100;
        w_flush = 4'b0010;
      end else if (w_load_use) begin
        w_stall = 5'b11000;
        w_flush = 4'b0100;
      end
    end
  end

  assign PC_Stall      = w_stall[4] & ~rst;
  assign IF_ID_Stall   = w_stall[3] & ~rst;
  assign ID_EXE_Stall  = w_stall[2] & ~rst;
  assign EXE_MEM_Stall = w_stall[1] & ~rst;
  assign MEM_WB_Stall  = w_stall[0] & ~rst;
  assign IF_ID_Flush   = w_flush[3] & ~rst;
  assign ID_EXE_Flush  = w_flush[2] & ~rst;
  assign EXE_MEM_Flush = w_flush[1] & ~rst;
  assign MEM_WB_Flush  = w_flush[0] & ~rst;
  assign md_busy       = w_busy & ~rst;
  assign md_done       = r_md_done;
  assign md_cancel     = r_md_cancel;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue-based scoreboard.
module tb_pipeline_hazard_ctrl;

  // Output vector layout:
  // [11:7] Stall PC,IF_ID,ID_EXE,EXE_MEM,MEM_WB  [6:3] Flush IF_ID..MEM_WB
  // [2] md_busy  [1] md_done  [0] md_cancel
  localparam logic [11:0] E_NONE   = 12'b00000_0000_000;
  localparam logic [11:0] E_ALLST  = 12'b11111_0000_000;
  localparam logic [11:0] E_ALLSTB = 12'b11111_0000_100;
  localparam logic [11:0] E_FLUSH  = 12'b00000_1111_000;
  localparam logic [11:0] E_ISSUE  = 12'b11100_0010_000;
  localparam logic [11:0] E_BUSY   = 12'b11100_0010_100;
  localparam logic [11:0] E_BUBBLE = 12'b11000_0100_000;
  localparam logic [11:0] E_DONE   = 12'b00000_0000_010;
  localparam logic [11:0] E_CANCEL = 12'b00000_0000_001;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, exe_regdst = '0;
  logic       id_use_rs = 0, id_use_rt = 0, exe_load = 0;
  logic       exe_mul_start = 0, exe_div_start = 0;
  logic       if_wait = 0, mem_wait = 0, exc_flush = 0;

  logic PC_Stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall;
  logic IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush;
  logic md_busy, md_done, md_cancel;

  pipeline_hazard_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .exe_load(exe_load), .exe_regdst(exe_regdst),
    .exe_mul_start(exe_mul_start), .exe_div_start(exe_div_start),
    .if_wait(if_wait), .mem_wait(mem_wait), .exc_flush(exc_flush),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EXE_Stall(ID_EXE_Stall),
    .EXE_MEM_Stall(EXE_MEM_Stall), .MEM_WB_Stall(MEM_WB_Stall),
    .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Flush(ID_EXE_Flush),
    .EXE_MEM_Flush(EXE_MEM_Flush), .MEM_WB_Flush(MEM_WB_Flush),
    .md_busy(md_busy), .md_done(md_done), .md_cancel(md_cancel)
  );

  logic [11:0] got;
  assign got = {PC_Stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall,
                IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush,
                md_busy, md_done, md_cancel};

  // Scoreboard
  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Monitor: compare whatever the DUT presents this cycle against the queue head
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b (t=%0t)", nm, got, e, $time);
      end
    end
  end

  // Driver tasks
  task automatic nc();
    @(posedge clk);
    #1;
    rst = 0; id_rs = '0; id_rt = '0; exe_regdst = '0;
    id_use_rs = 0; id_use_rt = 0; exe_load = 0;
    exe_mul_start = 0; exe_div_start = 0;
    if_wait = 0; mem_wait = 0; exc_flush = 0;
  endtask

  task automatic chk(input string nm, input logic [11:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    // Reset with exc_flush and mem_wait active: nothing may leak out or latch
    nc(); rst = 1; exc_flush = 1; mem_wait = 1; chk("rst_0", E_NONE);
    nc(); rst = 1; exc_flush = 1; mem_wait = 1; chk("rst_1", E_NONE);
    nc(); chk("idle_0", E_NONE);
    nc(); chk("idle_1", E_NONE);

    // DIV: issue + 32 busy cycles stalled, then done pulse
    nc(); exe_div_start = 1; chk("div_issue", E_ISSUE);
    for (int i = 0; i < 32; i++) begin
      nc(); chk($sformatf("div_busy_%0d", i), E_BUSY);
    end
    nc(); chk("div_done", E_DONE);
    nc(); chk("div_after", E_NONE);

    // Load-use hazards
    nc(); exe_load = 1; exe_regdst = 5'd5; id_rs = 5'd5; id_use_rs = 1;
    chk("lu_rs", E_BUBBLE);
    nc(); chk("lu_one_bubble", E_NONE);
    nc(); exe_load = 1; exe_regdst = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    chk("lu_r0", E_NONE);
    nc(); exe_load = 1; exe_regdst = 5'd7; id_rt = 5'd7; id_use_rt = 1;
    chk("lu_rt", E_BUBBLE);
    nc(); exe_load = 1; exe_regdst = 5'd7; id_rt = 5'd7; id_use_rt = 0;
    chk("lu_rt_unused", E_NONE);
    nc(); exe_load = 0; exe_regdst = 5'd9; id_rs = 5'd9; id_use_rs = 1;
    chk("lu_not_load", E_NONE);

    // if_wait and priorities
    nc(); if_wait = 1; chk("ifw", E_BUBBLE);
    nc(); if_wait = 1; mem_wait = 1; chk("memw_over_ifw", E_ALLST);
    nc(); if_wait = 1; exc_flush = 1; chk("exc_over_ifw", E_FLUSH);
    nc(); chk("exc_once", E_NONE);

    // Deferred exception flush behind mem_wait
    nc(); mem_wait = 1; exc_flush = 1; chk("defer_0", E_ALLST);
    nc(); mem_wait = 1; chk("defer_1", E_ALLST);
    nc(); mem_wait = 1; chk("defer_2", E_ALLST);
    nc(); chk("defer_flush", E_FLUSH);
    nc(); chk("defer_once", E_NONE);

    // Exception during DIV at cnt=10: cancel pulse, no done
    nc(); exe_div_start = 1; chk("dc_issue", E_ISSUE);
    for (int i = 0; i < 22; i++) begin
      nc(); chk($sformatf("dc_busy_%0d", i), E_BUSY);
    end
    nc(); exc_flush = 1; chk("dc_flush", E_FLUSH);
    nc(); chk("dc_cancel", E_CANCEL);
    nc(); chk("dc_no_done", E_NONE);

    // MUL with mem_wait over the last busy cycle: done deferred
    nc(); exe_mul_start = 1; chk("mw_issue", E_ISSUE);
    nc(); mem_wait = 1; chk("mw_hold_0", E_ALLSTB);
    nc(); mem_wait = 1; chk("mw_hold_1", E_ALLSTB);
    nc(); chk("mw_last", E_BUSY);
    nc(); chk("mw_done", E_DONE);
    nc(); chk("mw_after", E_NONE);

    // Plain MUL, and DIV winning over MUL when both start
    nc(); exe_mul_start = 1; chk("mul_issue", E_ISSUE);
    nc(); chk("mul_busy", E_BUSY);
    nc(); chk("mul_done", E_DONE);
    nc(); exe_mul_start = 1; exe_div_start = 1; chk("both_issue", E_ISSUE);
    nc(); chk("both_busy_0", E_BUSY);
    nc(); exe_mul_start = 1; chk("both_busy_1", E_BUSY);
    nc(); exc_flush = 1; chk("both_flush", E_FLUSH);
    nc(); chk("both_cancel", E_CANCEL);

    // Reset mid-divide aborts silently
    nc(); exe_div_start = 1; chk("rd_issue", E_ISSUE);
    nc(); chk("rd_busy_0", E_BUSY);
    nc(); chk("rd_busy_1", E_BUSY);
    nc(); rst = 1; chk("rd_rst", E_NONE);
    nc(); chk("rd_no_cancel", E_NONE);
    nc(); chk("rd_idle", E_NONE);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Drives Stall/Flush for the PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB pipeline registers.
- Sequences multi-cycle MUL/DIV in EXE with a busy counter, resolves load-use hazards, honours SRAM wait requests, and defers exception flushes until outstanding memory transactions finish.

Parameters:
- MUL_CYCLES, 2, EXE occupancy of MUL/MULT(U) including issue cycle (>=1).
- DIV_CYCLES, 33, EXE occupancy of DIV(U) including issue cycle (>=1).
- CNT_W, 6, busy counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs  in  5  ID-stage rs index
- id_rt  in  5  ID-stage rt index
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- exe_load  in  1  EXE instruction is a load
- exe_regdst  in  5  EXE destination register
- exe_mul_start  in  1  EXE holds a new MUL-class instruction
- exe_div_start  in  1  EXE holds a new DIV-class instruction
- if_wait  in  1  instruction SRAM not ready
- mem_wait  in  1  data SRAM not ready
- exc_flush  in  1  exception/ERET committed in MEM (single-cycle pulse)
- PC_Stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall  out  1 each
- IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_WB_Flush  out  1 each
- md_busy  out  1  MUL/DIV unit occupied
- md_done  out  1  one-cycle pulse, MUL/DIV result valid in EXE this cycle
- md_cancel  out  1  one-cycle pulse, in-flight MUL/DIV aborted

Behaviour:
- All outputs combinational from state + inputs, except md_done and md_cancel, which are registered.
- Reset: state IDLE, cnt=0, flush_pend=0; every Stall/Flush, md_busy, md_done and md_cancel read 0 the cycle after rst is sampled. Reset mid-divide aborts silently (no md_cancel).
- FSM states: IDLE, BUSY.
- Priority per cycle: exception flush > mem_wait > if_wait > BUSY > load-use > none.
- Exception, with flush_eff = (exc_flush | flush_pend) & ~mem_wait:
  - flush_eff asserts all four Flush outputs and all Stalls 0; state->IDLE, cnt->0, flush_pend->0.
  - If the flush interrupted BUSY, md_cancel pulses the next cycle.
  - exc_flush while mem_wait: flush_pend<=1, held until mem_wait falls.
- mem_wait (no flush_eff): all five Stalls 1, no Flush. cnt keeps decrementing to 0 and saturates; BUSY is not left while mem_wait=1.
- if_wait only: PC_Stall=IF_ID_Stall=1, ID_EXE_Flush=1; later stages advance.
- MUL/DIV issue, IDLE with exe_*_start and no higher event:
  - cnt<=MUL_CYCLES-1 or DIV_CYCLES-1 (div wins if both); go BUSY if that value >0, else md_done next cycle.
  - Issue cycle stalls PC, IF_ID, ID_EXE, EXE_MEM_Flush=1.
- BUSY:
  - md_busy=1; PC/IF_ID/ID_EXE Stall=1; EXE_MEM_Flush=1 (bubble into MEM).
  - cnt decrements each cycle. In the cycle cnt==1 and mem_wait=0: next state IDLE and md_done=1 next cycle; in that cycle no stalls, and EXE advances normally.
  - exe_*_start is ignored while BUSY.
- Load-use, IDLE, no higher event: exe_load & exe_regdst!=0 & ((id_use_rs & id_rs==exe_regdst) | (id_use_rt & id_rt==exe_regdst)):
  - PC_Stall=IF_ID_Stall=1, ID_EXE_Flush=1; exactly one bubble.
- A Stall and a Flush are never both 1 on the same register.

Test Plan:
- rst=1 two cycles with exc_flush=1, mem_wait=1 -> all outputs 0; after release with no requests all outputs stay 0.
- exe_div_start pulse, DIV_CYCLES=33 -> md_busy high 32 cycles, ID_EXE_Stall=1 and EXE_MEM_Flush=1 for 33 cycles total, md_done single pulse at cycle 33, then no stalls.
- exe_load=1, exe_regdst=5, id_rs=5, id_use_rs=1 -> one cycle PC_Stall=IF_ID_Stall=ID_EXE_Flush=1. Repeat with exe_regdst=0 -> no stall.
- mem_wait=1 for 3 cycles with exc_flush pulse in cycle 1 -> all Stalls 1 for 3 cycles; flush asserted on all four Flush outputs in the cycle mem_wait falls, once only.
- DIV in BUSY at cnt=10, exc_flush -> all Flush 1 same cycle, md_cancel pulse next cycle, md_busy 0, no md_done.
- MUL_CYCLES=2 with mem_wait high during the last BUSY cycle -> md_done deferred until mem_wait low, then single pulse.
